// File: rtl/activity_led_multi_pkg.sv
// activity_led_multi_pkg: shared definitions for the multi-channel activity LED
// block and anything that drives it.
//   MODE_*  : 2-bit per-channel mode encodings
//   cnt_w() : stretch counter width for a given stretch duration
package activity_led_multi_pkg;

    localparam logic [1:0] MODE_STRETCH = 2'b00;  // on while stretch active
    localparam logic [1:0] MODE_TOGGLE  = 2'b01;  // flips on each rising edge
    localparam logic [1:0] MODE_BLINK   = 2'b10;  // blinks while stretch active
    localparam logic [1:0] MODE_DIM     = 2'b11;  // full on when active, dim when idle

    // WIDTH-1 always fits in clog2(WIDTH) bits for WIDTH >= 2.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/activity_led_multi_if.sv
// activity_led_multi_if: activity inputs, mode selects and LED/status outputs.
//   i    : raw asynchronous activity inputs, one per channel
//   mode : per-channel mode, channel k at [2k+1:2k]
//   o    : registered LED drives
//   act  : registered stretch-active status
interface activity_led_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0]   i;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   o;
    logic [N_CH-1:0]   act;

    modport master (output i, output mode, input o, input act);
    modport slave  (input i, input mode, output o, output act);
endinterface

// File: rtl/activity_led_ch.sv
// activity_led_ch: one LED channel -- synchroniser, edge detector, stretch
// counter, toggle bit and output mode mux.
//   clk, rst_n : clock, async active-low reset
//   in_i       : raw activity input
//   mode_i     : output mode for this channel
//   blink_i    : shared blink phase (prescaler MSB)
//   dim_i      : shared dim PWM phase
//   o_o        : LED drive (ACTIVE_LEVEL = on)
//   act_o      : stretch active
module activity_led_ch
    import activity_led_multi_pkg::*;
#(
    parameter int   WIDTH        = 256,
    parameter logic ACTIVE_LEVEL = 1'b0,
    parameter int   SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_i,
    input  logic [1:0] mode_i,
    input  logic       blink_i,
    input  logic       dim_i,
    output logic       o_o,
    output logic       act_o
);
    localparam int CW = cnt_w(WIDTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   edge_q, rise_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   tog_q, tog_d;
    logic                   act_q, act_d;
    logic                   o_q, o_d;
    logic                   s, on;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d = cnt_q;
        if (edge_q)
            cnt_d = CW'(WIDTH - 1);
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
        // Active covers the load cycle too, so a stretch lasts exactly WIDTH cycles.
        act_d = edge_q | (cnt_q != '0);
        tog_d = tog_q ^ rise_q;
        on    = 1'b0;
        case (mode_i)
            MODE_STRETCH: on = act_d;
            MODE_TOGGLE:  on = tog_d;
            MODE_BLINK:   on = act_d & blink_i;
            default:      on = act_d | dim_i;
        endcase
        o_d = on ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            edge_q <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
            tog_q  <= 1'b0;
            act_q  <= 1'b0;
            o_q    <= ~ACTIVE_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            dly_q  <= s;
            // Edge is registered to keep the synchroniser-to-counter path short.
            edge_q <= s ^ dly_q;
            rise_q <= s & ~dly_q;
            cnt_q  <= cnt_d;
            tog_q  <= tog_d;
            act_q  <= act_d;
            o_q    <= o_d;
        end
    end

    assign o_o   = o_q;
    assign act_o = act_q;
endmodule

// File: rtl/activity_led_multi.sv
// activity_led_multi: N_CH independent activity LEDs sharing one dim PWM
// counter and one blink prescaler.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of activity_led_multi_if (i, mode in; o, act out)
module activity_led_multi
    import activity_led_multi_pkg::*;
#(
    parameter int   N_CH           = 4,
    parameter int   WIDTH          = 256,
    parameter logic ACTIVE_LEVEL   = 1'b0,
    parameter int   SYNC_STAGES    = 2,
    parameter int   PWM_BITS       = 8,
    parameter int   DIM_DUTY       = 16,
    parameter int   BLINK_DIV_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    activity_led_multi_if.slave  bus
);
    logic [PWM_BITS-1:0]       pwm_q;
    logic [BLINK_DIV_BITS-1:0] presc_q;
    logic                      dim_on, blink_on;
    logic [N_CH-1:0]           o_w, act_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q   <= '0;
            presc_q <= '0;
        end else begin
            pwm_q   <= pwm_q + 1'b1;
            presc_q <= presc_q + 1'b1;
        end
    end

    assign dim_on   = (pwm_q < PWM_BITS'(DIM_DUTY));
    assign blink_on = presc_q[BLINK_DIV_BITS-1];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        activity_led_ch #(
            .WIDTH        (WIDTH),
            .ACTIVE_LEVEL (ACTIVE_LEVEL),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_i    (bus.i[k]),
            .mode_i  (bus.mode[2*k+1 -: 2]),
            .blink_i (blink_on),
            .dim_i   (dim_on),
            .o_o     (o_w[k]),
            .act_o   (act_w[k])
        );
    end

    assign bus.o   = o_w;
    assign bus.act = act_w;
endmodule

// File: tb/tb_activity_led_multi.sv
// tb_activity_led_multi: directed bench driving two identical instances that
// differ only in ACTIVE_LEVEL (dut0 = 0, dut1 = 1).
module tb_activity_led_multi;
    import activity_led_multi_pkg::*;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int SS = 2;
    localparam int PB = 4;
    localparam int DD = 4;
    localparam int BB = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0]   in_v;
    logic [2*N-1:0] mode_v;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    activity_led_multi_if #(.N_CH(N)) bus0 ();
    activity_led_multi_if #(.N_CH(N)) bus1 ();

    assign bus0.i = in_v;
    assign bus1.i = in_v;
    assign bus0.mode = mode_v;
    assign bus1.mode = mode_v;

    activity_led_multi #(.N_CH(N), .WIDTH(W), .ACTIVE_LEVEL(1'b0), .SYNC_STAGES(SS),
        .PWM_BITS(PB), .DIM_DUTY(DD), .BLINK_DIV_BITS(BB))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    activity_led_multi #(.N_CH(N), .WIDTH(W), .ACTIVE_LEVEL(1'b1), .SYNC_STAGES(SS),
        .PWM_BITS(PB), .DIM_DUTY(DD), .BLINK_DIV_BITS(BB))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic at(input int c);
        while (cyc < c) step();
    endtask

    task automatic cmp_duts(input string tag);
        logic [N-1:0] ninv;
        ninv = ~bus0.o;
        chk({tag, "_o_inv"}, 32'(bus1.o), 32'(ninv));
        chk({tag, "_act_eq"}, 32'(bus1.act), 32'(bus0.act));
    endtask

    initial begin
        int n_on, n_rise, n_on1;
        logic prev;
        rst_n  = 1'b0;
        in_v   = '0;
        mode_v = {MODE_STRETCH, MODE_STRETCH};
        step(); step(); step();
        chk("rst_o0", 32'(bus0.o), 32'h3);
        chk("rst_o1", 32'(bus1.o), 32'h0);
        chk("rst_act", 32'(bus0.act), 32'h0);
        rst_n = 1'b1;
        cyc = 0;

        // Single stretch on ch0: sampled at 10, on at 13, off at 29.
        at(9);  in_v[0] = 1'b1;
        at(12); chk("lat_act_early", 32'(bus0.act[0]), 32'h0);
                chk("lat_o_early", 32'(bus0.o[0]), 32'h1);
        at(13); chk("lat_act", 32'(bus0.act[0]), 32'h1);
                chk("lat_o_on", 32'(bus0.o[0]), 32'h0);
                chk("ch1_idle", 32'(bus0.o[1]), 32'h1);
                cmp_duts("c13");
        at(28); chk("str_last_on", 32'(bus0.o[0]), 32'h0);
        at(29); chk("str_off_o", 32'(bus0.o[0]), 32'h1);
                chk("str_off_act", 32'(bus0.act[0]), 32'h0);

        // Retrigger: edges sampled at 50 and 60, off at 79.
        at(49); in_v[0] = 1'b0;
        at(52); chk("rt_before", 32'(bus0.act[0]), 32'h0);
        at(59); in_v[0] = 1'b1;
        while (cyc < 78) begin
            step();
            chk("rt_cont", 32'(bus0.o[0]), 32'h0);
        end
        at(79); chk("rt_off", 32'(bus0.o[0]), 32'h1);

        // Toggle on ch1: rises at 90/130/170, falls at 110/150.
        at(80); mode_v[3:2] = MODE_TOGGLE;
        at(89); in_v[1] = 1'b1;
        at(92); chk("tog_pre", 32'(bus0.o[1]), 32'h1);
        at(93); chk("tog1_on", 32'(bus0.o[1]), 32'h0);
                chk("tog1_act", 32'(bus0.act[1]), 32'h1);
                cmp_duts("c93");
        at(109); in_v[1] = 1'b0;
        at(113); chk("fall1_keep", 32'(bus0.o[1]), 32'h0);
                 chk("fall1_act", 32'(bus0.act[1]), 32'h1);
        at(129); in_v[1] = 1'b1;
        at(133); chk("tog2_off", 32'(bus0.o[1]), 32'h1);
        at(149); in_v[1] = 1'b0;
        at(153); chk("fall2_keep", 32'(bus0.o[1]), 32'h1);
                 chk("fall2_act", 32'(bus0.act[1]), 32'h1);
        at(169); in_v[1] = 1'b1;
        at(173); chk("tog3_on", 32'(bus0.o[1]), 32'h0);

        // Dim on ch0: idle duty 4/16, then solid for a 16-cycle stretch.
        at(180); mode_v[1:0] = MODE_DIM;
        n_on = 0;
        repeat (16) begin
            step();
            if (bus0.o[0] == 1'b0) n_on++;
        end
        chk("dim_idle_duty", 32'(n_on), 32'd4);
        at(199); in_v[0] = 1'b0;
        at(202);
        repeat (16) begin
            step();
            chk("dim_solid", 32'(bus0.o[0]), 32'h0);
        end
        cmp_duts("c218");

        // Blink on ch0: dark when idle, half duty while active.
        at(230); mode_v[1:0] = MODE_BLINK;
        repeat (8) begin
            step();
            chk("blink_idle", 32'(bus0.o[0]), 32'h1);
        end
        at(239); in_v[0] = 1'b1;
        at(242);
        n_on = 0;
        repeat (16) begin
            step();
            if (bus0.o[0] == 1'b0) n_on++;
        end
        chk("blink_duty", 32'(n_on), 32'd8);
        at(259); chk("blink_end_act", 32'(bus0.act[0]), 32'h0);

        // Reset mid-stretch with inputs held high, then exactly one stretch.
        at(260); mode_v[1:0] = MODE_STRETCH;
        at(269); in_v[0] = 1'b0;
        at(275); chk("pre_rst_act", 32'(bus0.act[0]), 32'h1);
        rst_n = 1'b0;
        in_v[0] = 1'b1;
        #1;
        chk("rst_mid_o0", 32'(bus0.o), 32'h3);
        chk("rst_mid_o1", 32'(bus1.o), 32'h0);
        chk("rst_mid_act", 32'(bus0.act), 32'h0);
        step(); step(); step();
        rst_n = 1'b1;
        n_on = 0; n_on1 = 0; n_rise = 0; prev = 1'b0;
        repeat (40) begin
            step();
            if (bus0.o[0] == 1'b0) n_on++;
            if (bus0.act[1]) n_on1++;
            if (bus0.act[0] && !prev) n_rise++;
            prev = bus0.act[0];
        end
        chk("post_rst_len0", 32'(n_on), 32'd16);
        chk("post_rst_len1", 32'(n_on1), 32'd16);
        chk("post_rst_rises", 32'(n_rise), 32'd1);
        cmp_duts("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
